// File: rtl/mult_stage_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   SizeDefault : default product width (operands are half of this)
//   state_e     : FSM encoding; 2'd3 is unused and recovers to StIdle
package mult_stage_pkg;

    localparam int unsigned SizeDefault = 128;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mult_stage.sv
// Sequential SIZE/2 x SIZE/2 -> SIZE unsigned multiplier, radix-2 shift-add.
// Runs a fixed SIZE/2 iterations per product (no early exit) so timing does not
// depend on operand values. Operands and product use valid/ready handshakes.
// Ports:
//   clk            : clock, all state updates on rising edge
//   rst            : synchronous active-high reset
//   input_a_*      : multiplicand stream (tdata SIZE/2 bits)
//   input_b_*      : multiplier stream (tdata SIZE/2 bits)
//   output_*       : product stream (tdata SIZE bits)
module mult_stage
    import mult_stage_pkg::*;
#(
    parameter int unsigned SIZE = SizeDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE/2-1:0] input_a_tdata,
    input  logic              input_a_tvalid,
    output logic              input_a_tready,
    input  logic [SIZE/2-1:0] input_b_tdata,
    input  logic              input_b_tvalid,
    output logic              input_b_tready,
    output logic [SIZE-1:0]   output_tdata,
    output logic              output_tvalid,
    input  logic              output_tready
);

    localparam int unsigned Half = SIZE / 2;
    localparam int unsigned CntW = $clog2(Half);
    localparam logic [CntW-1:0] CntLast = CntW'(Half - 1);

    state_e            state_q;
    logic              have_a_q, have_b_q;
    logic [Half-1:0]   hold_a_q, hold_b_q;
    logic [SIZE-1:0]   mcand_q, mcand_d;
    logic [Half-1:0]   mplier_q, mplier_d;
    logic [SIZE-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0]   tdata_q;
    logic              tvalid_q;
    logic              a_hs, b_hs;

    assign input_a_tready = ~have_a_q;
    assign input_b_tready = ~have_b_q;
    assign output_tdata   = tdata_q;
    assign output_tvalid  = tvalid_q;

    always_comb begin
        a_hs     = input_a_tvalid & ~have_a_q;
        b_hs     = input_b_tvalid & ~have_b_q;
        // Product fits in SIZE bits, so the accumulator never overflows.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            have_a_q <= 1'b0;
            have_b_q <= 1'b0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            // Operand capture is independent of FSM state; at most one pair buffered.
            if (a_hs) begin
                hold_a_q <= input_a_tdata;
                have_a_q <= 1'b1;
            end
            if (b_hs) begin
                hold_b_q <= input_b_tdata;
                have_b_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (have_a_q && have_b_q) begin
                        state_q  <= StBusy;
                        mcand_q  <= {{Half{1'b0}}, hold_a_q};
                        mplier_q <= hold_b_q;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        // Clearing here frees the holding regs for the next pair.
                        have_a_q <= 1'b0;
                        have_b_q <= 1'b0;
                    end
                end
                StBusy: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (cnt_q == CntLast) begin
                        tdata_q  <= acc_d;
                        tvalid_q <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (output_tready) begin
                        tvalid_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
